// File: rtl/idli_pkg.sv
// Shared types for the SQI arbiter: data/address widths, FSM states, requester ids.
package idli_pkg;

    typedef logic [3:0]  sqi_data_t;
    typedef logic [15:0] sqi_addr_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CMD,
        ARB_XFER,
        ARB_TURN
    } arb_state_t;

    typedef enum logic {
        ARB_SRC_FE,
        ARB_SRC_LS
    } arb_src_t;

    // Counter width for n states, never narrower than one bit.
    function automatic int arb_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/idli_arb_rr_m.sv
// Two-input round-robin pick. The pointer only moves on a contested grant,
// and then it moves to the requester that lost.
module idli_arb_rr_m
    import idli_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_en,
    input  logic     i_fe_req,
    input  logic     i_ls_req,
    output arb_src_t o_pick
);

    arb_src_t r_ptr;
    arb_src_t w_pick;

    // A lone requester wins outright; a tie goes to the pointer.
    always_comb begin
        w_pick = ARB_SRC_FE;
        if (i_fe_req && i_ls_req) begin
            w_pick = r_ptr;
        end else if (i_ls_req) begin
            w_pick = ARB_SRC_LS;
        end
    end

    assign o_pick = w_pick;

    // Hand priority to the loser of a tie; fetch wins the first tie after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= ARB_SRC_FE;
        end else if (i_en && i_fe_req && i_ls_req) begin
            r_ptr <= (w_pick == ARB_SRC_FE) ? ARB_SRC_LS : ARB_SRC_FE;
        end
    end

endmodule

// File: rtl/idli_sqi_arb_m.sv
// Arbiter/sequencer sharing the SQI controller between fetch (FE) and
// load/store (LS): grant, issue one command, count beats, then turnaround.
module idli_sqi_arb_m
    import idli_pkg::*;
#(
    parameter int BEATS       = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic      i_arb_gck,
    input  logic      i_arb_rst,
    input  logic      i_arb_fe_req,
    input  sqi_addr_t i_arb_fe_addr,
    output logic      o_arb_fe_gnt,
    output logic      o_arb_fe_beat,
    output logic      o_arb_fe_done,
    input  logic      i_arb_ls_req,
    input  logic      i_arb_ls_wr,
    input  sqi_addr_t i_arb_ls_addr,
    input  sqi_data_t i_arb_ls_wdata,
    output logic      o_arb_ls_gnt,
    output logic      o_arb_ls_beat,
    output logic      o_arb_ls_done,
    output sqi_data_t o_arb_rdata,
    output logic      o_arb_sqi_req,
    output logic      o_arb_sqi_wr,
    output sqi_addr_t o_arb_sqi_addr,
    input  logic      i_arb_sqi_acp,
    input  logic      i_arb_sqi_vld,
    input  sqi_data_t i_arb_sqi_rdata,
    output sqi_data_t o_arb_sqi_wdata
);

    localparam int              CW        = arb_cnt_w(BEATS);
    localparam logic [CW-1:0]   LAST_BEAT = CW'(BEATS - 1);
    localparam logic [2:0]      LAST_TURN = 3'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    arb_state_t    r_state;
    arb_src_t      r_owner;
    logic [CW-1:0] r_beat_cnt;
    logic [2:0]    r_turn_cnt;
    logic          r_fe_gnt, r_fe_beat, r_fe_done;
    logic          r_ls_gnt, r_ls_beat, r_ls_done;
    logic          r_sqi_req, r_sqi_wr;
    sqi_addr_t     r_sqi_addr;
    sqi_data_t     r_rdata;

    arb_src_t      w_pick;
    logic          w_idle, w_any, w_beat, w_last;

    assign w_idle = (r_state == ARB_IDLE);
    assign w_any  = i_arb_fe_req | i_arb_ls_req;
    // Beats outside XFER (e.g. while still in CMD) are not counted.
    assign w_beat = (r_state == ARB_XFER) && i_arb_sqi_vld;
    assign w_last = w_beat && (r_beat_cnt == LAST_BEAT);

    idli_arb_rr_m u_rr (
        .i_clk    (i_arb_gck),
        .i_rst    (i_arb_rst),
        .i_en     (w_idle),
        .i_fe_req (i_arb_fe_req),
        .i_ls_req (i_arb_ls_req),
        .o_pick   (w_pick)
    );

    // Transaction FSM with all controller-facing and requester-facing outputs registered.
    always_ff @(posedge i_arb_gck) begin
        if (i_arb_rst) begin
            r_state    <= ARB_IDLE;
            r_owner    <= ARB_SRC_FE;
            r_beat_cnt <= '0;
            r_turn_cnt <= '0;
            r_fe_gnt   <= 1'b0;
            r_fe_beat  <= 1'b0;
            r_fe_done  <= 1'b0;
            r_ls_gnt   <= 1'b0;
            r_ls_beat  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_sqi_req  <= 1'b0;
            r_sqi_wr   <= 1'b0;
            r_sqi_addr <= '0;
            r_rdata    <= '0;
        end else begin
            r_fe_beat <= w_beat && (r_owner == ARB_SRC_FE);
            r_ls_beat <= w_beat && (r_owner == ARB_SRC_LS);
            r_fe_done <= w_last && (r_owner == ARB_SRC_FE);
            r_ls_done <= w_last && (r_owner == ARB_SRC_LS);
            if (w_beat) begin
                r_rdata <= i_arb_sqi_rdata;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_owner    <= w_pick;
                        r_fe_gnt   <= (w_pick == ARB_SRC_FE);
                        r_ls_gnt   <= (w_pick == ARB_SRC_LS);
                        r_sqi_addr <= (w_pick == ARB_SRC_FE) ? i_arb_fe_addr : i_arb_ls_addr;
                        r_sqi_wr   <= (w_pick == ARB_SRC_LS) && i_arb_ls_wr;
                        r_sqi_req  <= 1'b1;
                        r_state    <= ARB_CMD;
                    end
                end
                ARB_CMD: begin
                    if (i_arb_sqi_acp) begin
                        r_sqi_req <= 1'b0;
                        r_state   <= ARB_XFER;
                    end
                end
                ARB_XFER: begin
                    if (w_last) begin
                        r_beat_cnt <= '0;
                        r_fe_gnt   <= 1'b0;
                        r_ls_gnt   <= 1'b0;
                        r_state    <= (TURN_CYCLES == 0) ? ARB_IDLE : ARB_TURN;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                ARB_TURN: begin
                    if (r_turn_cnt == LAST_TURN) begin
                        r_turn_cnt <= '0;
                        r_state    <= ARB_IDLE;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_arb_fe_gnt    = r_fe_gnt;
    assign o_arb_fe_beat   = r_fe_beat;
    assign o_arb_fe_done   = r_fe_done;
    assign o_arb_ls_gnt    = r_ls_gnt;
    assign o_arb_ls_beat   = r_ls_beat;
    assign o_arb_ls_done   = r_ls_done;
    assign o_arb_rdata     = r_rdata;
    assign o_arb_sqi_req   = r_sqi_req;
    assign o_arb_sqi_wr    = r_sqi_wr;
    assign o_arb_sqi_addr  = r_sqi_addr;
    // Write nibble passes straight through so the controller sees it in the beat cycle.
    assign o_arb_sqi_wdata = (r_ls_gnt && r_sqi_wr) ? i_arb_ls_wdata : '0;

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Bench for idli_sqi_arb_m: two configurations (BEATS=4/TURN=1 and
// BEATS=1/TURN=0) exercised one after the other against a transaction model.
module tb_idli_sqi_arb_m;
    import idli_pkg::*;

    localparam int B0 = 4;
    localparam int T0 = 1;
    localparam int B1 = 1;
    localparam int T1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst = 2'b11;
    logic       fe_req = 1'b0, ls_req = 1'b0, ls_wr = 1'b0, acp = 1'b0, vld = 1'b0;
    sqi_addr_t  fe_addr = '0, ls_addr = '0;
    sqi_data_t  ls_wdata = '0, sqi_rdata = '0;

    logic [1:0] fe_gnt, fe_beat, fe_done, ls_gnt, ls_beat, ls_done, sqi_req, sqi_wr;
    sqi_data_t  rdata [2];
    sqi_data_t  wdata [2];
    sqi_addr_t  saddr [2];

    idli_sqi_arb_m #(.BEATS(B0), .TURN_CYCLES(T0)) u_dut (
        .i_arb_gck(clk), .i_arb_rst(rst[0]),
        .i_arb_fe_req(fe_req), .i_arb_fe_addr(fe_addr),
        .o_arb_fe_gnt(fe_gnt[0]), .o_arb_fe_beat(fe_beat[0]), .o_arb_fe_done(fe_done[0]),
        .i_arb_ls_req(ls_req), .i_arb_ls_wr(ls_wr), .i_arb_ls_addr(ls_addr),
        .i_arb_ls_wdata(ls_wdata),
        .o_arb_ls_gnt(ls_gnt[0]), .o_arb_ls_beat(ls_beat[0]), .o_arb_ls_done(ls_done[0]),
        .o_arb_rdata(rdata[0]), .o_arb_sqi_req(sqi_req[0]), .o_arb_sqi_wr(sqi_wr[0]),
        .o_arb_sqi_addr(saddr[0]), .i_arb_sqi_acp(acp), .i_arb_sqi_vld(vld),
        .i_arb_sqi_rdata(sqi_rdata), .o_arb_sqi_wdata(wdata[0])
    );

    idli_sqi_arb_m #(.BEATS(B1), .TURN_CYCLES(T1)) u_dut_b1 (
        .i_arb_gck(clk), .i_arb_rst(rst[1]),
        .i_arb_fe_req(fe_req), .i_arb_fe_addr(fe_addr),
        .o_arb_fe_gnt(fe_gnt[1]), .o_arb_fe_beat(fe_beat[1]), .o_arb_fe_done(fe_done[1]),
        .i_arb_ls_req(ls_req), .i_arb_ls_wr(ls_wr), .i_arb_ls_addr(ls_addr),
        .i_arb_ls_wdata(ls_wdata),
        .o_arb_ls_gnt(ls_gnt[1]), .o_arb_ls_beat(ls_beat[1]), .o_arb_ls_done(ls_done[1]),
        .o_arb_rdata(rdata[1]), .o_arb_sqi_req(sqi_req[1]), .o_arb_sqi_wr(sqi_wr[1]),
        .o_arb_sqi_addr(saddr[1]), .i_arb_sqi_acp(acp), .i_arb_sqi_vld(vld),
        .i_arb_sqi_rdata(sqi_rdata), .o_arb_sqi_wdata(wdata[1])
    );

    int npass = 0, nfail = 0, ntot = 0;
    int cyc = 0, sel = 0, nb = B0, nt = T0, rise_cyc = 0;
    bit rr_ls = 1'b0;   // model: 1 = LS wins the next tie

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass = npass + 1;
        else begin
            nfail = nfail + 1;
            $error("FAIL %s: observed %0h expected %0h (cfg %0d, cycle %0d)", tag, obs, exp, sel, cyc);
        end
    endtask

    task automatic chk_out(input logic gf, input logic gl, input logic bf, input logic bl,
                           input logic df, input logic dl, input logic sr);
        chk("fe_gnt",  32'(fe_gnt[sel]),  32'(gf));
        chk("ls_gnt",  32'(ls_gnt[sel]),  32'(gl));
        chk("fe_beat", 32'(fe_beat[sel]), 32'(bf));
        chk("ls_beat", 32'(ls_beat[sel]), 32'(bl));
        chk("fe_done", 32'(fe_done[sel]), 32'(df));
        chk("ls_done", 32'(ls_done[sel]), 32'(dl));
        chk("sqi_req", 32'(sqi_req[sel]), 32'(sr));
    endtask

    task automatic chk_zero_regs();
        chk("sqi_addr_rst", 32'(saddr[sel]), 32'h0);
        chk("sqi_wr_rst",   32'(sqi_wr[sel]), 32'h0);
        chk("rdata_rst",    32'(rdata[sel]), 32'h0);
    endtask

    task automatic do_reset(input int s);
        rst[s] = 1'b1;
        repeat (2) step();
        rst[s] = 1'b0;
        rr_ls  = 1'b0;
    endtask

    // One complete transaction starting from IDLE with the requests presently driven.
    // The model picks the winner, then walks CMD, XFER and TURN cycle by cycle.
    task automatic txn(input int acp_dly, input int max_gap, input bit noise,
                       input bit rereq, input bit seq);
        bit        w_ls, exp_wr, last;
        sqi_addr_t exp_addr;
        sqi_data_t rd, wd;
        int        g;
        if (fe_req && ls_req) begin
            w_ls  = rr_ls;
            rr_ls = !w_ls;
        end else begin
            w_ls = ls_req;
        end
        exp_addr = w_ls ? ls_addr : fe_addr;
        exp_wr   = w_ls && ls_wr;
        step();
        rise_cyc = cyc;
        chk_out(!w_ls, w_ls, 0, 0, 0, 0, 1);
        chk("sqi_addr", 32'(saddr[sel]), 32'(exp_addr));
        chk("sqi_wr",   32'(sqi_wr[sel]), 32'(exp_wr));
        for (int i = 0; i < acp_dly; i++) begin
            vld = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            vld = 1'b0;
            chk_out(!w_ls, w_ls, 0, 0, 0, 0, 1);
        end
        acp = 1'b1;
        step();
        acp = 1'b0;
        chk_out(!w_ls, w_ls, 0, 0, 0, 0, 0);
        for (int k = 0; k < nb; k++) begin
            g = seq ? 0 : int'($urandom_range(0, max_gap));
            for (int i = 0; i < g; i++) begin
                step();
                chk_out(!w_ls, w_ls, 0, 0, 0, 0, 0);
            end
            rd = seq ? 4'(k + 1)   : 4'($urandom);
            wd = seq ? 4'(k + 'hA) : 4'($urandom);
            sqi_rdata = rd;
            ls_wdata  = wd;
            vld       = 1'b1;
            #1;
            chk("sqi_wdata", 32'(wdata[sel]), exp_wr ? 32'(wd) : 32'h0);
            step();
            vld  = 1'b0;
            last = (k == nb - 1);
            chk_out(!w_ls && !last, w_ls && !last, !w_ls, w_ls,
                    !w_ls && last, w_ls && last, 0);
            if (!exp_wr) chk("rdata", 32'(rdata[sel]), 32'(rd));
            if (last) begin
                if (w_ls) begin
                    ls_req = rereq;
                    if (rereq) ls_addr = 16'($urandom);
                end else begin
                    fe_req = rereq;
                    if (rereq) fe_addr = 16'($urandom);
                end
            end
        end
        for (int i = 0; i < nt; i++) begin
            step();
            chk_out(0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic rand_txns(input int n);
        for (int it = 0; it < n; it++) begin
            if (!fe_req && !ls_req) begin
                repeat ($urandom_range(1, 2)) begin
                    step();
                    chk_out(0, 0, 0, 0, 0, 0, 0);
                end
            end
            if (!fe_req) begin
                fe_req  = 1'($urandom_range(0, 1));
                fe_addr = 16'($urandom);
            end
            if (!ls_req) begin
                ls_req  = 1'($urandom_range(0, 1));
                ls_addr = 16'($urandom);
                ls_wr   = 1'($urandom_range(0, 1));
            end
            if (!fe_req && !ls_req) fe_req = 1'b1;
            txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        int p;
        // ---------------- configuration 0: BEATS=4, TURN_CYCLES=1
        sel = 0; nb = B0; nt = T0;
        do_reset(0);
        chk_out(0, 0, 0, 0, 0, 0, 0);
        chk_zero_regs();

        // FE alone, acp two cycles late, read nibbles 1..4
        fe_req = 1'b1; fe_addr = 16'h1234;
        txn(2, 0, 1'b0, 1'b0, 1'b1);

        // Tie after reset goes to FE; FE re-requests so LS wins the next tie,
        // then the following tie is back to FE.
        do_reset(0);
        fe_req = 1'b1; fe_addr = 16'h1111;
        ls_req = 1'b1; ls_addr = 16'h2222; ls_wr = 1'b0;
        txn(0, 0, 1'b0, 1'b1, 1'b1);
        txn(0, 0, 1'b0, 1'b0, 1'b1);
        ls_req = 1'b1; ls_addr = 16'h3333;
        chk("tie_model_fe", 32'(rr_ls), 32'h0);
        txn(1, 1, 1'b0, 1'b0, 1'b1);
        chk("tie_owner_fe", 32'(rr_ls), 32'h1);
        txn(0, 0, 1'b0, 1'b0, 1'b1);

        // LS store, nibbles A..D on consecutive beats
        fe_req = 1'b0;
        ls_req = 1'b1; ls_addr = 16'h00F0; ls_wr = 1'b1;
        txn(1, 0, 1'b0, 1'b0, 1'b1);
        ls_wr = 1'b0;

        // Reset lands on the second beat; requester drops req mid-transfer too.
        fe_req = 1'b1; fe_addr = 16'h5A5A;
        step();
        chk_out(1, 0, 0, 0, 0, 0, 1);
        acp = 1'b1; step(); acp = 1'b0;
        fe_req = 1'b0;
        chk_out(1, 0, 0, 0, 0, 0, 0);
        sqi_rdata = 4'h7; vld = 1'b1; step(); vld = 1'b0;
        chk_out(1, 0, 1, 0, 0, 0, 0);
        chk("rdata_pre_rst", 32'(rdata[0]), 32'h7);
        sqi_rdata = 4'h9; vld = 1'b1; rst[0] = 1'b1;
        step();
        vld = 1'b0; rst[0] = 1'b0; rr_ls = 1'b0;
        chk_out(0, 0, 0, 0, 0, 0, 0);
        chk_zero_regs();
        step();
        chk_out(0, 0, 0, 0, 0, 0, 0);
        fe_req = 1'b1; fe_addr = 16'hBEEF;
        txn(0, 1, 1'b1, 1'b0, 1'b0);

        rand_txns(20);

        // ---------------- configuration 1: BEATS=1, TURN_CYCLES=0
        rst[0] = 1'b1;
        fe_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
        sel = 1; nb = B1; nt = T1;
        do_reset(1);
        chk_out(0, 0, 0, 0, 0, 0, 0);
        chk_zero_regs();

        // FE held continuously with zero-latency acp: requests spaced BEATS+2
        fe_req = 1'b1; fe_addr = 16'h0042;
        txn(0, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            p = rise_cyc;
            txn(0, 0, 1'b0, 1'b1, 1'b1);
            chk("req_spacing", 32'(rise_cyc - p), 32'(B1 + 2));
        end
        fe_req = 1'b0;
        step();
        chk_out(0, 0, 0, 0, 0, 0, 0);

        // Tie then single LS store in the one-beat configuration
        fe_req = 1'b1; ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 16'h00F0;
        txn(0, 0, 1'b0, 1'b0, 1'b1);
        txn(1, 0, 1'b0, 1'b0, 1'b1);
        ls_wr = 1'b0;

        rand_txns(12);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
